// File: rtl/ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the instruction prefetch controller and its buffer:
// default field widths, the instruction-word width formula and the FSM state
// encoding.
// Ports: none (package).
// ----------------------------------------------------------------------------
package ctrl_pkg;

    localparam int RFAWIDTH_DEF = 5;
    localparam int DAWIDTH_DEF  = 12;
    localparam int IAWIDTH_DEF  = 6;

    // An instruction word holds a 2-bit opcode, two register-file addresses
    // and four data-RAM addresses.
    function automatic int instr_width(input int rfa, input int da);
        return 2 + 2 * rfa + 4 * da;
    endfunction

    localparam int INSTRWIDTH_DEF = instr_width(RFAWIDTH_DEF, DAWIDTH_DEF);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10
    } state_t;

endpackage

// File: rtl/ctrl_iw_fifo.sv
// ----------------------------------------------------------------------------
// ctrl_iw_fifo
// Two-entry instruction-word FIFO. Entry 0 is always the head, so the head
// word and its valid flag come straight from flops.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push, din         write strobe and word
//   pop               remove head (ignored when empty)
//   head              head word (entry 0)
//   full, empty       occupancy flags
//   count             occupancy 0..2
// ----------------------------------------------------------------------------
module ctrl_iw_fifo
    import ctrl_pkg::*;
#(
    parameter int WIDTH = INSTRWIDTH_DEF
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] entry0_r;
    logic [WIDTH-1:0] entry1_r;
    logic [1:0]       count_r;
    logic             do_pop_s;
    logic             do_push_s;

    // A push into a full buffer is only legal when the head leaves the same cycle.
    assign do_pop_s  = pop && (count_r != 2'd0);
    assign do_push_s = push && ((count_r != 2'd2) || do_pop_s);

    // Storage and occupancy update; entry 1 shifts into entry 0 on pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            entry0_r <= '0;
            entry1_r <= '0;
            count_r  <= 2'd0;
        end else begin
            case ({do_push_s, do_pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        entry0_r <= din;
                    end else begin
                        entry1_r <= din;
                    end
                    count_r <= count_r + 2'd1;
                end
                2'b01: begin
                    if (count_r == 2'd2) begin
                        entry0_r <= entry1_r;
                    end
                    count_r <= count_r - 2'd1;
                end
                2'b11: begin
                    if (count_r == 2'd1) begin
                        entry0_r <= din;
                    end else begin
                        entry0_r <= entry1_r;
                        entry1_r <= din;
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    assign head  = entry0_r;
    assign count = count_r;
    assign full  = (count_r == 2'd2);
    assign empty = (count_r == 2'd0);

endmodule

// File: rtl/ctrl_iprefetch.sv
// ----------------------------------------------------------------------------
// ctrl_iprefetch
// Instruction prefetch controller. On start it reads instruction memory from
// address 0 up to prog_last, buffers returned words in a 2-entry FIFO and
// presents the head word to the consumer with a valid/ready handshake.
// Optional build macro CTRL_IPREFETCH_LOOP_EN: the address wraps to 0 after
// prog_last and fetching continues until stop.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start, stop           one-cycle control pulses
//   prog_last             last program address, captured on accepted start
//   imem_rd_en, imem_addr instruction-memory read request
//   imem_rdata            read data, valid one cycle after imem_rd_en
//   en_fetch              consumer ready
//   iw_valid, instr_word  head of the prefetch buffer
//   busy, done            status; done pulses on return to idle
// ----------------------------------------------------------------------------
module ctrl_iprefetch
    import ctrl_pkg::*;
#(
    parameter int RFAWIDTH = RFAWIDTH_DEF,
    parameter int DAWIDTH  = DAWIDTH_DEF,
    parameter int IAWIDTH  = IAWIDTH_DEF,
    localparam int INSTRWIDTH = instr_width(RFAWIDTH, DAWIDTH)
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [IAWIDTH-1:0]    prog_last,
    output logic                  imem_rd_en,
    output logic [IAWIDTH-1:0]    imem_addr,
    input  logic [INSTRWIDTH-1:0] imem_rdata,
    input  logic                  en_fetch,
    output logic                  iw_valid,
    output logic [INSTRWIDTH-1:0] instr_word,
    output logic                  busy,
    output logic                  done
);

    localparam logic [IAWIDTH-1:0] ADDR_ONE = {{(IAWIDTH-1){1'b0}}, 1'b1};

    state_t               state_r;
    state_t               state_nx;
    logic                 done_r;
    logic                 done_nx;
    logic [IAWIDTH-1:0]   addr_r;
    logic [IAWIDTH-1:0]   last_r;
    logic                 inflight_r;
    logic                 pop_s;
    logic                 issue_s;
    logic                 at_last_s;
    logic                 full_s;
    logic                 empty_s;
    logic [1:0]           count_s;
    logic [2:0]           proj_s;

    ctrl_iw_fifo #(
        .WIDTH (INSTRWIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight_r),
        .din   (imem_rdata),
        .pop   (pop_s),
        .head  (instr_word),
        .full  (full_s),
        .empty (empty_s),
        .count (count_s)
    );

    assign pop_s     = !empty_s && en_fetch;
    assign at_last_s = (addr_r == last_r);

    // Occupancy after this edge: the word returning now is pushed, a transfer
    // pops. A new read lands one edge later, so it needs this to be below 2.
    assign proj_s = {1'b0, count_s} + {2'b00, inflight_r} - {2'b00, pop_s};

    // Read issue; the full-and-no-pop term is a redundant guard against overflow.
    always_comb begin
        issue_s = 1'b0;
        if ((state_r == ST_RUN) && !stop && (proj_s < 3'd2) && !(full_s && !pop_s)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Next-state and done decode.
    always_comb begin
        state_nx = state_r;
        done_nx  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nx = ST_RUN;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_RUN: begin
`ifdef CTRL_IPREFETCH_LOOP_EN
                if (stop) begin
                    state_nx = ST_DRAIN;
                end else begin
                    state_nx = ST_RUN;
                end
`else
                if (stop || (issue_s && at_last_s)) begin
                    state_nx = ST_DRAIN;
                end else begin
                    state_nx = ST_RUN;
                end
`endif
            end
            ST_DRAIN: begin
                // No reads issue in DRAIN, so an empty projection means nothing is left.
                if (proj_s == 3'd0) begin
                    state_nx = ST_IDLE;
                    done_nx  = 1'b1;
                end else begin
                    state_nx = ST_DRAIN;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // State, address counter, captured program end and in-flight flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            done_r     <= 1'b0;
            addr_r     <= '0;
            last_r     <= '0;
            inflight_r <= 1'b0;
        end else begin
            state_r    <= state_nx;
            done_r     <= done_nx;
            inflight_r <= issue_s;
            if ((state_r == ST_IDLE) && start) begin
                addr_r <= '0;
                last_r <= prog_last;
            end else if (issue_s) begin
`ifdef CTRL_IPREFETCH_LOOP_EN
                if (at_last_s) begin
                    addr_r <= '0;
                end else begin
                    addr_r <= addr_r + ADDR_ONE;
                end
`else
                addr_r <= addr_r + ADDR_ONE;
`endif
            end else if (done_nx) begin
                addr_r <= '0;
            end
        end
    end

    assign imem_rd_en = issue_s;
    assign imem_addr  = addr_r;
    assign iw_valid   = !empty_s;
    assign busy       = (state_r != ST_IDLE);
    assign done       = done_r;

endmodule

// File: doc/ctrl_iprefetch.md
CTRL_IPREFETCH -- requirements
Module: ctrl_iprefetch

Interface
REQ-001 Parameter RFAWIDTH, 5, register-address field width of an instruction word.
REQ-002 Parameter DAWIDTH, 12, data-RAM address field width of an instruction word.
REQ-003 Parameter IAWIDTH, 6, instruction-memory address width.
REQ-004 Derived constant INSTRWIDTH SHALL equal 2 + 2*RFAWIDTH + 4*DAWIDTH (60 at defaults).
REQ-005 clk  in  1  clock; all state updates on posedge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 start  in  1  one-cycle pulse: begin program from address 0.
REQ-008 stop  in  1  one-cycle pulse: cease issuing reads, drain, finish.
REQ-009 prog_last  in  IAWIDTH  address of last instruction, sampled on accepted start.
REQ-010 imem_rd_en  out  1  instruction-memory read strobe.
REQ-011 imem_addr  out  IAWIDTH  instruction-memory read address.
REQ-012 imem_rdata  in  INSTRWIDTH  read data, valid exactly 1 cycle after imem_rd_en.
REQ-013 en_fetch  in  1  consumer ready.
REQ-014 iw_valid  out  1  instr_word valid.
REQ-015 instr_word  out  INSTRWIDTH  head word of prefetch buffer.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 done  out  1  one-cycle pulse on return to IDLE after normal completion or stop.

Function
REQ-018 A transfer SHALL occur at the posedge where iw_valid and en_fetch are both high; iw_valid and instr_word SHALL be registered and SHALL NOT depend combinationally on en_fetch.
REQ-019 FSM states IDLE, RUN, DRAIN; IDLE->RUN on start; RUN->DRAIN on stop or after issuing read of prog_last (non-loop); DRAIN->IDLE when buffer empty and no read in flight, asserting done that cycle.
REQ-020 start SHALL be ignored when busy; stop SHALL be ignored in IDLE and DRAIN.
REQ-021 In RUN, addresses SHALL be issued 0,1,...,prog_last in order, one per cycle at most.
REQ-022 Prefetch buffer SHALL be a 2-entry FIFO; a read SHALL issue only when occupancy + in-flight - (transfer this cycle) < 2, so no returned word is ever dropped.
REQ-023 With en_fetch held high, sustained throughput SHALL be one word per cycle; first iw_valid SHALL rise 2 cycles after accepted start.
REQ-024 prog_last = 0 SHALL produce exactly one word then done.
REQ-025 Read data returned after stop SHALL still be buffered and delivered; no read SHALL issue after stop.
REQ-026 instr_word SHALL hold its value while iw_valid high and en_fetch low.

Reset
REQ-027 On rst: state IDLE, buffer empty, in-flight read discarded, iw_valid 0, instr_word 0, imem_rd_en 0, imem_addr 0, busy 0, done 0.
REQ-028 rst mid-operation SHALL abort without done pulse; rst SHALL override simultaneous start.

Configuration
REQ-029 Macro CTRL_IPREFETCH_LOOP_EN defined: after issuing prog_last, address SHALL wrap to 0 and RUN continues until stop.
REQ-030 Macro undefined: RUN->DRAIN after prog_last issued; no wrap logic compiled.

Structure
REQ-031 INSTRWIDTH formula, field widths and FSM state encodings SHALL live in shared package ctrl_pkg, reused by the fetch register.
REQ-032 The 2-entry FIFO SHALL be sub-module ctrl_iw_fifo (push, pop, full, empty, count).

Verification
REQ-033 prog_last=3, en_fetch=1 constant -> words at addr 0..3 on 4 consecutive cycles, iw_valid rising 2 cycles after start, done 1 cycle after last transfer.
REQ-034 prog_last=5, en_fetch toggling 1,0,1,0 -> all 6 words in order, none duplicated or lost, instr_word stable while stalled.
REQ-035 prog_last=0 -> single word addr 0, then done, busy low.
REQ-036 prog_last=10, stop after 3 transfers -> in-flight/buffered words (max addr 5) delivered, no further imem_rd_en, done.
REQ-037 rst asserted with 2 words buffered -> next cycle iw_valid=0, busy=0, no done; subsequent start restarts at addr 0.
REQ-038 LOOP_EN, prog_last=2, 8 transfers -> address sequence 0,1,2,0,1,2,0,1; stop -> drain, done.
